// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pong_pkg
// Purpose : Shared types and constants for the pong engine: FSM state
//           encoding, readout select codes and the paddle-distance width rule.
// Revision: 1.0  initial release
// ============================================================================
package pong_pkg;

  // FSM states; encodings are visible on state_out
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } pong_state_e;

  // Readout select codes
  localparam logic [2:0] SEL_BALL_X  = 3'd0;
  localparam logic [2:0] SEL_BALL_Y  = 3'd1;
  localparam logic [2:0] SEL_PAD_L   = 3'd2;
  localparam logic [2:0] SEL_PAD_R   = 3'd3;
  localparam logic [2:0] SEL_SCORES  = 3'd4;
  localparam logic [2:0] SEL_RALLY   = 3'd5;

  // Ball-to-paddle distance needs one extra bit so the difference of two
  // unsigned coordinates can be held as a signed value without overflow.
  function automatic int dist_width(input int coord_w);
    return coord_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_paddle.sv
`default_nettype none
// ============================================================================
// Module  : pong_paddle
// Purpose : One paddle position register. Moves one cell per enabled step,
//           saturating so the whole paddle stays on screen. With track_en
//           set it follows the target coordinate instead of up/dn.
// Revision: 1.0  initial release
// ============================================================================
module pong_paddle #(
  parameter int COORD_W     = 8,
  parameter int SCREEN_H    = 120,
  parameter int PADDLE_HALF = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up,
  input  logic               dn,
  input  logic               track_en,
  input  logic [COORD_W-1:0] target,
  output logic [COORD_W-1:0] pos
);

  localparam logic [COORD_W-1:0] c_pos_min = COORD_W'(PADDLE_HALF);
  localparam logic [COORD_W-1:0] c_pos_max = COORD_W'(SCREEN_H - 1 - PADDLE_HALF);
  localparam logic [COORD_W-1:0] c_pos_mid = COORD_W'(SCREEN_H / 2);

  logic [COORD_W-1:0] pos_q, pos_d;
  logic               mv_up, mv_dn;

  // Choose direction (manual or tracking) and apply saturating step
  always_comb begin
    mv_up = track_en ? (target < pos_q) : (up && !dn);
    mv_dn = track_en ? (target > pos_q) : (dn && !up);
    pos_d = pos_q;
    if (en) begin
      if (mv_up) begin
        pos_d = (pos_q > c_pos_min) ? pos_q - 1'b1 : pos_q;
      end else if (mv_dn) begin
        pos_d = (pos_q < c_pos_max) ? pos_q + 1'b1 : pos_q;
      end
    end
  end

  // Position register, centred on reset
  always_ff @(posedge clk) begin
    if (reset) pos_q <= c_pos_mid;
    else       pos_q <= pos_d;
  end

  assign pos = pos_q;

endmodule
`default_nettype wire

// File: rtl/pong_engine.sv
`default_nettype none
// ============================================================================
// Module  : pong_engine
// Purpose : Complete pong game core: ball kinematics, wall bounce, paddle
//           collision, scoring, serve pause, win detection and a registered
//           readout bus. All game state advances only on tick.
//           Optional build macro PONG_AUTO_RIGHT_EN makes the right paddle
//           track the ball and ignore right_up/right_dn.
// Revision: 1.0  initial release
// ============================================================================
module pong_engine
  import pong_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int PADDLE_HALF = 4,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int PAUSE_TICKS = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               left_up,
  input  logic               left_dn,
  input  logic               right_up,
  input  logic               right_dn,
  input  logic [2:0]         sel,
  output logic [COORD_W-1:0] data_out,
  output logic [1:0]         state_out,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over
);

  localparam int c_dist_w  = dist_width(COORD_W);
  localparam int c_pause_w = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

  localparam logic [COORD_W-1:0]   c_x_min  = COORD_W'(1);
  localparam logic [COORD_W-1:0]   c_x_max  = COORD_W'(SCREEN_W - 2);
  localparam logic [COORD_W-1:0]   c_y_max  = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0]   c_x_mid  = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0]   c_y_mid  = COORD_W'(SCREEN_H / 2);
  localparam logic [c_dist_w-1:0]  c_reach  = c_dist_w'(PADDLE_HALF);
  localparam logic [SCORE_W-1:0]   c_win    = SCORE_W'(WIN_SCORE);
  localparam logic [c_pause_w-1:0] c_pause_init = c_pause_w'(PAUSE_TICKS - 1);

`ifdef PONG_AUTO_RIGHT_EN
  localparam logic c_right_track = 1'b1;
`else
  localparam logic c_right_track = 1'b0;
`endif

  // Parameter sanity checks at elaboration
  if (SCREEN_W > 2**COORD_W || SCREEN_H > 2**COORD_W) begin : g_chk_coord
    $error("pong_engine: screen does not fit in COORD_W");
  end
  if (2*PADDLE_HALF + 1 > SCREEN_H) begin : g_chk_paddle
    $error("pong_engine: paddle taller than screen");
  end
  if (PAUSE_TICKS < 1) begin : g_chk_pause
    $error("pong_engine: PAUSE_TICKS must be at least 1");
  end

  pong_state_e          state_q, state_d;
  logic [COORD_W-1:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic                 vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
  logic [c_pause_w-1:0] pause_q, pause_d;
  logic [COORD_W-1:0]   rally_q, rally_d;
  logic [COORD_W-1:0]   data_q, data_d;

  logic [COORD_W-1:0]   pad_l, pad_r;
  logic                 pad_en;
  logic signed [c_dist_w-1:0] diff_l, diff_r;
  logic [c_dist_w-1:0]  dist_l, dist_r;
  logic                 hit_l, hit_r;
  logic                 vy_neg_n;
  logic [SCORE_W-1:0]   score_inc;
  logic [COORD_W-1:0]   rally_inc;

  // Paddles move in every state except OVER
  assign pad_en = tick && (state_q != ST_OVER);

  pong_paddle #(.COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_HALF(PADDLE_HALF)) u_pad_l (
    .clk(clk), .reset(reset), .en(pad_en), .up(left_up), .dn(left_dn),
    .track_en(1'b0), .target(ball_y_q), .pos(pad_l)
  );

  pong_paddle #(.COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_HALF(PADDLE_HALF)) u_pad_r (
    .clk(clk), .reset(reset), .en(pad_en), .up(right_up), .dn(right_dn),
    .track_en(c_right_track), .target(ball_y_q), .pos(pad_r)
  );

  // Paddle reach test on the pre-step ball y using a signed difference
  always_comb begin
    diff_l = $signed({1'b0, ball_y_q}) - $signed({1'b0, pad_l});
    diff_r = $signed({1'b0, ball_y_q}) - $signed({1'b0, pad_r});
    dist_l = diff_l[c_dist_w-1] ? c_dist_w'(-diff_l) : c_dist_w'(diff_l);
    dist_r = diff_r[c_dist_w-1] ? c_dist_w'(-diff_r) : c_dist_w'(diff_r);
    hit_l  = (dist_l <= c_reach);
    hit_r  = (dist_r <= c_reach);
  end

  // Next-state logic for the game FSM, ball, scores, rally and readout
  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    vx_neg_d  = vx_neg_q;
    vy_neg_d  = vy_neg_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    pause_d   = pause_q;
    rally_d   = rally_q;
    vy_neg_n  = vy_neg_q;
    score_inc = '0;
    rally_inc = (rally_q == '1) ? rally_q : rally_q + 1'b1;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          // Wall bounce first, then move with the updated direction
          if (ball_y_q == '0 && vy_neg_q)           vy_neg_n = 1'b0;
          else if (ball_y_q == c_y_max && !vy_neg_q) vy_neg_n = 1'b1;
          vy_neg_d = vy_neg_n;
          ball_y_d = vy_neg_n ? ball_y_q - 1'b1 : ball_y_q + 1'b1;

          if (ball_x_q == c_x_min && vx_neg_q) begin
            if (hit_l) begin
              vx_neg_d = 1'b0;
              ball_x_d = c_x_min + 1'b1;
              rally_d  = rally_inc;
            end else begin
              // Left player lost: next serve heads left
              score_inc = score_r_q + 1'b1;
              score_r_d = score_inc;
              vx_neg_d  = 1'b1;
              rally_d   = '0;
              pause_d   = c_pause_init;
              state_d   = (score_inc == c_win) ? ST_OVER : ST_POINT;
            end
          end else if (ball_x_q == c_x_max && !vx_neg_q) begin
            if (hit_r) begin
              vx_neg_d = 1'b1;
              ball_x_d = c_x_max - 1'b1;
              rally_d  = rally_inc;
            end else begin
              // Right player lost: next serve heads right
              score_inc = score_l_q + 1'b1;
              score_l_d = score_inc;
              vx_neg_d  = 1'b0;
              rally_d   = '0;
              pause_d   = c_pause_init;
              state_d   = (score_inc == c_win) ? ST_OVER : ST_POINT;
            end
          end else begin
            ball_x_d = vx_neg_q ? ball_x_q - 1'b1 : ball_x_q + 1'b1;
          end
        end
        ST_POINT: begin
          if (pause_q == '0) begin
            ball_x_d = c_x_mid;
            state_d  = ST_PLAY;
          end else begin
            pause_d = pause_q - 1'b1;
          end
        end
        default: begin // ST_OVER
          if (start) begin
            score_l_d = '0;
            score_r_d = '0;
            ball_x_d  = c_x_mid;
            ball_y_d  = c_y_mid;
            vx_neg_d  = 1'b0;
            vy_neg_d  = 1'b0;
            rally_d   = '0;
            state_d   = ST_PLAY;
          end
        end
      endcase
    end

    case (sel)
      SEL_BALL_X: data_d = ball_x_q;
      SEL_BALL_Y: data_d = ball_y_q;
      SEL_PAD_L:  data_d = pad_l;
      SEL_PAD_R:  data_d = pad_r;
      SEL_SCORES: data_d = COORD_W'({score_l_q, score_r_q});
      SEL_RALLY:  data_d = rally_q;
      default:    data_d = '0;
    endcase
  end

  // State registers; reset overrides any step in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ball_x_q  <= c_x_mid;
      ball_y_q  <= c_y_mid;
      vx_neg_q  <= 1'b0;
      vy_neg_q  <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      pause_q   <= '0;
      rally_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      vx_neg_q  <= vx_neg_d;
      vy_neg_q  <= vy_neg_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      pause_q   <= pause_d;
      rally_q   <= rally_d;
      data_q    <= data_d;
    end
  end

  assign data_out    = data_q;
  assign state_out   = state_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign game_over   = (state_q == ST_OVER);

endmodule
`default_nettype wire
